// File: rtl/muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: op codes and FSM state encoding.
package muldiv_pkg;

   // Operation codes presented on the op port (6 and 7 are no-ops)
   localparam logic [2:0] OP_MULT  = 3'd0;
   localparam logic [2:0] OP_MULTU = 3'd1;
   localparam logic [2:0] OP_DIV   = 3'd2;
   localparam logic [2:0] OP_DIVU  = 3'd3;
   localparam logic [2:0] OP_MTHI  = 3'd4;
   localparam logic [2:0] OP_MTLO  = 3'd5;

   // Control FSM states
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_FIN  = 2'd2
   } state_t;

   // True for the ops whose operands are interpreted as two's complement
   function automatic logic is_signed_op(input logic [2:0] code);
      return (code == OP_MULT) || (code == OP_DIV);
   endfunction

endpackage

// File: rtl/muldiv_core_step.sv
// One radix-2 iteration of the multiply/divide datapath (purely combinational).
// Multiply: acc = {partial product, remaining multiplier bits}; add opb when acc[0]
//           is set, then shift the whole accumulator right by one.
// Divide:   acc[WIDTH-1:0] holds the dividend being shifted out at the top and the
//           quotient being shifted in at the bottom; rem is the partial remainder.
//           A WIDTH+1 bit trial subtraction decides the quotient bit (restoring).
module muldiv_core_step
   import muldiv_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic                 is_div,
   input  logic [2*WIDTH-1:0]   acc,
   input  logic [WIDTH-1:0]     rem,
   input  logic [WIDTH-1:0]     opb,
   output logic [2*WIDTH-1:0]   acc_next,
   output logic [WIDTH-1:0]     rem_next
);

   logic [WIDTH:0] sum;
   logic [WIDTH:0] shifted;
   logic [WIDTH:0] diff;

   // Compute the next accumulator and partial remainder for one iteration
   always_comb begin
      sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opb};
      shifted  = {rem, acc[WIDTH-1]};
      diff     = shifted - {1'b0, opb};
      acc_next = acc;
      rem_next = rem;
      if (is_div) begin
         // diff[WIDTH] set means the trial subtraction borrowed: restore
         if (diff[WIDTH]) begin
            rem_next = shifted[WIDTH-1:0];
            acc_next = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-2:0], 1'b0};
         end else begin
            rem_next = diff[WIDTH-1:0];
            acc_next = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-2:0], 1'b1};
         end
      end else begin
         if (acc[0]) begin
            acc_next = {sum, acc[WIDTH-1:1]};
         end else begin
            acc_next = {1'b0, acc[2*WIDTH-1:1]};
         end
      end
   end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle HI/LO multiply/divide unit for the EX stage.
// Signed ops run on operand magnitudes; the sign is restored in FIN.
// Optional build macro MULDIV_FAST_MUL_EN: MULT/MULTU bypass CALC and use a
// combinational product in FIN (done two cycles after start). Divides unchanged.
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] rs,
   input  logic [WIDTH-1:0] rt,
   input  logic             flush,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t               state;
   state_t               next_state;
   logic [CNT_W-1:0]     cnt;
   logic [2*WIDTH-1:0]   acc;
   logic [WIDTH-1:0]     rem;
   logic [WIDTH-1:0]     opb;
   logic                 is_div;
   logic                 neg_res;    // negate product or quotient
   logic                 neg_rem;    // negate remainder (dividend was negative)
   logic                 div_zero;

   logic [WIDTH-1:0]     abs_rs;
   logic [WIDTH-1:0]     abs_rt;
   logic                 op_signed;
   logic [2*WIDTH-1:0]   acc_next;
   logic [WIDTH-1:0]     rem_next;
   logic [2*WIDTH-1:0]   prod;
   logic [2*WIDTH-1:0]   prod_fix;
   logic [WIDTH-1:0]     res_hi;
   logic [WIDTH-1:0]     res_lo;

   muldiv_core_step #(.WIDTH(WIDTH)) u_step (
      .is_div   (is_div),
      .acc      (acc),
      .rem      (rem),
      .opb      (opb),
      .acc_next (acc_next),
      .rem_next (rem_next)
   );

   // Operand magnitudes for signed ops; the most-negative value maps to itself as unsigned
   always_comb begin
      op_signed = is_signed_op(op);
      if (op_signed && rs[WIDTH-1]) begin
         abs_rs = -rs;
      end else begin
         abs_rs = rs;
      end
      if (op_signed && rt[WIDTH-1]) begin
         abs_rt = -rt;
      end else begin
         abs_rt = rt;
      end
   end

   // Final sign fix-up and HI/LO result selection used in FIN
   always_comb begin
`ifdef MULDIV_FAST_MUL_EN
      prod = {{WIDTH{1'b0}}, opb} * {{WIDTH{1'b0}}, acc[WIDTH-1:0]};
`else
      prod = acc;
`endif
      if (neg_res) begin
         prod_fix = -prod;
      end else begin
         prod_fix = prod;
      end
      if (is_div) begin
         res_hi = neg_rem ? -rem : rem;
         if (div_zero) begin
            res_lo = {WIDTH{1'b1}};
         end else if (neg_res) begin
            res_lo = -acc[WIDTH-1:0];
         end else begin
            res_lo = acc[WIDTH-1:0];
         end
      end else begin
         res_hi = prod_fix[2*WIDTH-1:WIDTH];
         res_lo = prod_fix[WIDTH-1:0];
      end
   end

   // Next-state logic; flush wins over every event in every state
   always_comb begin
      next_state = state;
      case (state)
         ST_IDLE: begin
            if (flush) begin
               next_state = ST_IDLE;
            end else if (start && ((op == OP_DIV) || (op == OP_DIVU))) begin
               next_state = ST_CALC;
            end else if (start && ((op == OP_MULT) || (op == OP_MULTU))) begin
`ifdef MULDIV_FAST_MUL_EN
               next_state = ST_FIN;
`else
               next_state = ST_CALC;
`endif
            end else begin
               next_state = ST_IDLE;
            end
         end
         ST_CALC: begin
            if (flush) begin
               next_state = ST_IDLE;
            end else if (cnt == LAST_CNT) begin
               next_state = ST_FIN;
            end else begin
               next_state = ST_CALC;
            end
         end
         ST_FIN:  next_state = ST_IDLE;
         default: next_state = ST_IDLE;
      endcase
   end

   // State register
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state <= ST_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Datapath, HI/LO and handshake registers
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         cnt      <= {CNT_W{1'b0}};
         acc      <= {(2*WIDTH){1'b0}};
         rem      <= {WIDTH{1'b0}};
         opb      <= {WIDTH{1'b0}};
         is_div   <= 1'b0;
         neg_res  <= 1'b0;
         neg_rem  <= 1'b0;
         div_zero <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         hi       <= {WIDTH{1'b0}};
         lo       <= {WIDTH{1'b0}};
      end else begin
         done <= 1'b0;
         busy <= (next_state != ST_IDLE);
         case (state)
            ST_IDLE: begin
               if (start && !flush) begin
                  case (op)
                     OP_MULT, OP_MULTU: begin
                        acc      <= {{WIDTH{1'b0}}, abs_rt};
                        opb      <= abs_rs;
                        rem      <= {WIDTH{1'b0}};
                        is_div   <= 1'b0;
                        neg_res  <= op_signed & (rs[WIDTH-1] ^ rt[WIDTH-1]);
                        neg_rem  <= 1'b0;
                        div_zero <= 1'b0;
                        cnt      <= {CNT_W{1'b0}};
                     end
                     OP_DIV, OP_DIVU: begin
                        acc      <= {{WIDTH{1'b0}}, abs_rs};
                        opb      <= abs_rt;
                        rem      <= {WIDTH{1'b0}};
                        is_div   <= 1'b1;
                        neg_res  <= op_signed & (rs[WIDTH-1] ^ rt[WIDTH-1]);
                        neg_rem  <= op_signed & rs[WIDTH-1];
                        div_zero <= (rt == {WIDTH{1'b0}});
                        cnt      <= {CNT_W{1'b0}};
                     end
                     OP_MTHI: hi <= rs;
                     OP_MTLO: lo <= rs;
                     default: ;
                  endcase
               end
            end
            ST_CALC: begin
               if (!flush) begin
                  acc <= acc_next;
                  rem <= rem_next;
                  cnt <= cnt + CNT_ONE;
               end
            end
            ST_FIN: begin
               if (!flush) begin
                  hi   <= res_hi;
                  lo   <= res_lo;
                  done <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Multi-cycle HI/LO multiply/divide unit for the MIPS EX stage.
- Replaces the single-cycle `*`, `/` and `%` on HI/LO with an iterative radix-2 datapath parametrised in WIDTH.
- Adds a busy/done handshake so the pipeline controller stalls MFHI/MFLO and new mul/div ops.
- Adds a flush input for squashed instructions and fully defined divide-by-zero/overflow results.

Parameters:
- WIDTH, 32, operand and HI/LO width; must be >= 4.
- CNT_W, $clog2(WIDTH+1), iteration counter width; derived, do not override.

Ports:
- CLK  input  1  clock, rising edge.
- RST_N  input  1  asynchronous active-low reset.
- start  input  1  op request; sampled only when state is IDLE.
- op  input  3  operation code, from package.
- rs  input  WIDTH  operand A: multiplicand, dividend, or MTHI/MTLO source.
- rt  input  WIDTH  operand B: multiplier or divisor.
- flush  input  1  abort in-flight op; HI/LO left unchanged.
- busy  output  1  high while an op is in CALC or FIN.
- done  output  1  one-cycle pulse; HI/LO hold the new result in this cycle.
- hi  output  WIDTH  HI register, direct register output.
- lo  output  WIDTH  LO register, direct register output.

Behaviour:
- Reset (RST_N low, async): HI=0, LO=0, state=IDLE, busy=0, done=0, counter=0. Reset mid-operation discards the op.
- States: IDLE -> CALC -> FIN -> IDLE.
- IDLE, start=1, op in {MULT, MULTU, DIV, DIVU}:
  - latch operands.
  - signed ops store absolute values and a result-sign flag.
  - go to CALC; counter=0.
- IDLE, start=1, op=MTHI or MTLO: HI (or LO) <= rs at that edge. Stay IDLE; no busy, no done.
- IDLE, any other op code: no-op.
- CALC: one iteration per cycle, WIDTH cycles, counter 0..WIDTH-1.
  - Multiply: shift-add over a 2*WIDTH accumulator.
  - Divide: restoring divide; partial remainder WIDTH+1 bits.
- FIN (1 cycle):
  - sign fix-up (two's complement of the product, quotient or remainder as required).
  - HI/LO written at the edge ending FIN.
- Cycle after FIN: state IDLE, done=1 for exactly one cycle.
- Latency: start sampled at edge k; busy=1 in cycles k+1..k+WIDTH+1; done=1 in cycle k+WIDTH+2. A new start is accepted in the done cycle.
- MULT/MULTU: {HI,LO} = full 2*WIDTH product, signed or unsigned.
- DIV: LO = quotient truncated toward zero; HI = remainder with the dividend's sign.
- DIVU: unsigned quotient and remainder.
- Divide by zero (DIV or DIVU): LO = all ones, HI = rs. Full WIDTH cycles are still taken.
- DIV with rs = most-negative and rt = -1: LO = most-negative, HI = 0.
- start while busy: ignored; the controller must stall on busy.
- flush while busy (CALC or FIN): return to IDLE next edge; HI/LO not written; no done.
- flush with start in IDLE: start is dropped.
- flush has priority over every other event except reset.
- hi/lo are always readable. Values are stale while busy=1; the controller stalls MFHI/MFLO on busy.

Optional Feature:
- Macro: MULDIV_FAST_MUL_EN.
- Defined:
  - MULT/MULTU skip CALC and use a combinational `*` in FIN.
  - done arrives 2 cycles after start (busy only during FIN).
  - Divide latency is unchanged.
- Undefined: all ops use the iterative path with the latency above.

Decomposition:
- Shared package muldiv_pkg holds:
  - op codes (3 bits): OP_MULT=0, OP_MULTU=1, OP_DIV=2, OP_DIVU=3, OP_MTHI=4, OP_MTLO=5, 6-7 no-op.
  - state encoding: ST_IDLE, ST_CALC, ST_FIN.
- One natural sub-module: muldiv_core_step. It is combinational and computes one shift-add or one restore step.
- The FSM, counter, sign handling and HI/LO registers stay in muldiv_unit.

Test Plan (WIDTH=32):
- MULT rs=0xFFFFFFFE, rt=3 -> busy for 33 cycles, done at start+34 cycles, HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- MULTU rs=0xFFFFFFFF, rt=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001. Then MTHI rs=0x12345678 -> HI=0x12345678 next cycle, LO unchanged, no done.
- Signed divide cases:
  - DIV rs=0xFFFFFFF9 (-7), rt=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - DIV rs=0x80000000, rt=0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIVU rs=7, rt=0 -> LO=0xFFFFFFFF, HI=0x00000007.
- Abort and handshake cases:
  - DIVU 100/3 with flush at CALC counter=10 -> HI/LO keep their prior values, no done.
  - A second start during busy is ignored; the next start after IDLE completes normally (LO=33, HI=1).
- Reset and fast-multiply cases:
  - RST_N pulsed low mid-MULT -> HI=LO=0, busy=0 immediately (async).
  - With MULDIV_FAST_MUL_EN, MULT 6*7 -> done at start+2, LO=42, HI=0.
